// File: rtl/mem_decoder.sv
// Address decoder fanning the core's single memory port out to NREG slave regions.
// Latency: s_valid one cycle after m_valid; m_ready one cycle after slave ready, miss reply after two.
// No backpressure: one outstanding request, m_valid outside IDLE is ignored.
module mem_decoder #(
    parameter int                  NREG     = 4,
    parameter logic [32*NREG-1:0]  REG_BASE = {32'h80000000, 32'h02000000, 32'h01000000, 32'h00000000},
    parameter logic [32*NREG-1:0]  REG_TOP  = {32'h90000000, 32'h0200C000, 32'h01000004, 32'h00000080},
    parameter int unsigned         TIMEOUT  = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                m_valid,
    input  logic                m_instr,
    input  logic [31:0]         m_addr,
    input  logic [31:0]         m_wdata,
    input  logic [3:0]          m_wstrb,
    output logic [31:0]         m_rdata,
    output logic                m_ready,
    output logic                m_error,
    output logic [NREG-1:0]     s_valid,
    output logic                s_instr,
    output logic [31:0]         s_addr,
    output logic [31:0]         s_wdata,
    output logic [3:0]          s_wstrb,
    input  logic [32*NREG-1:0]  s_rdata,
    input  logic [NREG-1:0]     s_ready
);

    localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            miss_q, miss_d;
    logic [31:0]     m_rdata_d;
    logic            m_ready_d, m_error_d;
    logic [NREG-1:0] s_valid_d;
    logic            s_instr_d;
    logic [31:0]     s_addr_d, s_wdata_d;
    logic [3:0]      s_wstrb_d;

    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic [31:0]     hit_base;
    logic            sel_ready;
    logic [31:0]     sel_rdata;

    // Region decode; scanning from the top index down lets the lowest index win on overlap.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_base = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m_addr >= REG_BASE[32*i +: 32] && m_addr < REG_TOP[32*i +: 32]) begin
                hit      = 1'b1;
                hit_idx  = SW'(i);
                hit_base = REG_BASE[32*i +: 32];
            end
        end
    end

    assign sel_ready = s_ready[sel_q];
    assign sel_rdata = s_rdata[32*int'(sel_q) +: 32];

    // Next-state and registered-output values; a miss spends two cycles in RESP so its reply lands at cycle 2.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        miss_d    = miss_q;
        m_rdata_d = m_rdata;
        m_ready_d = 1'b0;
        m_error_d = m_error;
        s_valid_d = '0;
        s_instr_d = s_instr;
        s_addr_d  = s_addr;
        s_wdata_d = s_wdata;
        s_wstrb_d = s_wstrb;
        case (state_q)
            IDLE: begin
                if (m_valid) begin
                    if (hit) begin
                        sel_d              = hit_idx;
                        s_valid_d[hit_idx] = 1'b1;
                        s_addr_d           = m_addr - hit_base;
                        s_instr_d          = m_instr;
                        s_wdata_d          = m_wdata;
                        s_wstrb_d          = m_wstrb;
                        cnt_d              = 32'd1;
                        state_d            = BUSY;
                    end else begin
                        miss_d  = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (sel_ready) begin
                    m_rdata_d = sel_rdata;
                    m_error_d = 1'b0;
                    m_ready_d = 1'b1;
                    state_d   = RESP;
                end else if (TIMEOUT != 0 && cnt_q == TIMEOUT) begin
                    m_rdata_d = '0;
                    m_error_d = 1'b1;
                    m_ready_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP: begin
                if (miss_q) begin
                    miss_d    = 1'b0;
                    m_rdata_d = '0;
                    m_error_d = 1'b1;
                    m_ready_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            miss_q  <= 1'b0;
            m_rdata <= '0;
            m_ready <= 1'b0;
            m_error <= 1'b0;
            s_valid <= '0;
            s_instr <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            m_rdata <= m_rdata_d;
            m_ready <= m_ready_d;
            m_error <= m_error_d;
            s_valid <= s_valid_d;
            s_instr <= s_instr_d;
            s_addr  <= s_addr_d;
            s_wdata <= s_wdata_d;
            s_wstrb <= s_wstrb_d;
        end
    end

endmodule

// File: tb/tb_mem_decoder.sv
// Bench for mem_decoder: directed map/timeout/abort cases followed by randomized transactions.
// Expected behaviour comes from a transaction-level model (region lookup plus response-cycle arithmetic).
// Slaves are emulated by the bench; unselected slaves inject stray ready pulses.
module tb_mem_decoder;
    localparam int NREG = 4;
    localparam int TO   = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_instr = 1'b0;
    logic [31:0]  m_addr = '0;
    logic [31:0]  m_wdata = '0;
    logic [3:0]   m_wstrb = '0;
    logic [31:0]  m_rdata;
    logic         m_ready;
    logic         m_error;
    logic [3:0]   s_valid;
    logic         s_instr;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [127:0] s_rdata = '0;
    logic [3:0]   s_ready = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata = '0;

    logic [31:0] base_a [4] = '{32'h00000000, 32'h01000000, 32'h02000000, 32'h80000000};
    logic [31:0] top_a  [4] = '{32'h00000080, 32'h01000004, 32'h0200C000, 32'h90000000};

    mem_decoder #(.NREG(NREG), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    function automatic int region(input logic [31:0] a);
        for (int i = 0; i < NREG; i++)
            if (a >= base_a[i] && a < top_a[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One transaction; k is the cycle (counted from m_valid) at which the selected slave pulses ready.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic instr, input int k, input logic [31:0] rdata);
        int r;
        int exp_c;
        int last;
        bit ok;
        logic [3:0] oh;
        r     = region(addr);
        ok    = (r >= 0) && (k <= TO);
        exp_c = (r < 0) ? 2 : (k <= TO ? k + 1 : TO + 1);
        last  = (r >= 0 && k > exp_c) ? k : exp_c;
        oh    = '0;
        if (r >= 0) oh[r] = 1'b1;
        chk("idle_m_ready", {31'd0, m_ready}, 32'd0);
        chk("rdata_hold", m_rdata, last_rdata);
        m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb; m_instr = instr;
        step();
        m_valid = 1'b0; m_addr = $urandom; m_wdata = $urandom; m_wstrb = 4'($urandom); m_instr = 1'b0;
        for (int c = 1; c <= last; c++) begin
            s_ready = '0;
            if ($urandom_range(0, 2) == 0) begin
                int o;
                o = int'($urandom_range(0, NREG - 1));
                if (o != r) begin
                    s_ready[o] = 1'b1;
                    s_rdata[32*o +: 32] = $urandom;
                end
            end
            if (r >= 0 && c == k) begin
                s_ready[r] = 1'b1;
                s_rdata[32*r +: 32] = rdata;
            end
            chk("s_valid", {28'd0, s_valid}, (c == 1) ? {28'd0, oh} : 32'd0);
            if (c == 1 && r >= 0) begin
                chk("s_addr", s_addr, addr - base_a[r]);
                chk("s_wdata", s_wdata, wdata);
                chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, wstrb});
                chk("s_instr", {31'd0, s_instr}, {31'd0, instr});
            end
            chk("m_ready", {31'd0, m_ready}, (c == exp_c) ? 32'd1 : 32'd0);
            if (c == exp_c) begin
                chk("m_error", {31'd0, m_error}, ok ? 32'd0 : 32'd1);
                chk("m_rdata", m_rdata, ok ? rdata : 32'd0);
                last_rdata = ok ? rdata : 32'd0;
            end
            step();
        end
        s_ready = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_ready"}, {31'd0, m_ready}, 32'd0);
        chk({tag, "_m_error"}, {31'd0, m_error}, 32'd0);
        chk({tag, "_m_rdata"}, m_rdata, 32'd0);
        chk({tag, "_s_valid"}, {28'd0, s_valid}, 32'd0);
        chk({tag, "_s_instr"}, {31'd0, s_instr}, 32'd0);
        chk({tag, "_s_addr"}, s_addr, 32'd0);
        chk({tag, "_s_wdata"}, s_wdata, 32'd0);
        chk({tag, "_s_wstrb"}, {28'd0, s_wstrb}, 32'd0);
    endtask

    logic [32:0] sizes [4] = '{33'h80, 33'h4, 33'hC000, 33'h10000000};

    initial begin
        // Reset held with a request pending: nothing may leak out.
        reset = 1'b0; m_valid = 1'b1; m_addr = 32'h80000000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all_zero("reset");
        end
        reset = 1'b1; m_valid = 1'b0; m_addr = '0;
        step();

        // Directed cases from the memory map.
        txn(32'h80000010, 32'h0, 4'h0, 1'b0, 3, 32'hDEADBEEF);
        txn(32'h01000003, 32'h0, 4'h0, 1'b1, 1, 32'h11112222);
        txn(32'h01000004, 32'h0, 4'h0, 1'b0, 1, 32'h0);
        txn(32'h0000007F, 32'h0, 4'h0, 1'b1, 2, 32'hA5A5A5A5);
        txn(32'h00000080, 32'h0, 4'h0, 1'b0, 1, 32'h0);
        txn(32'h02004000, 32'h12345678, 4'hF, 1'b0, 2, 32'h0BADF00D);
        txn(32'h80000020, 32'h0, 4'h0, 1'b0, 7, 32'hCAFEF00D);
        txn(32'h80000024, 32'h0, 4'h0, 1'b0, 4, 32'h5EED5EED);
        txn(32'h0200BFFC, 32'h0, 4'h0, 1'b0, 5, 32'h77777777);

        // Reset pulse in the middle of a RAM read aborts it.
        m_valid = 1'b1; m_addr = 32'h80000010; m_wstrb = 4'h0;
        step();
        m_valid = 1'b0;
        chk("abort_s_valid", {28'd0, s_valid}, 32'h8);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        s_ready[3] = 1'b1; s_rdata[127:96] = 32'h99999999;
        chk_all_zero("abort");
        step();
        s_ready = '0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_ready", {31'd0, m_ready}, 32'd0);
            step();
        end
        last_rdata = '0;
        txn(32'h80000010, 32'h0, 4'h0, 1'b0, 2, 32'h600DCAFE);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 5));
            if (kind < NREG) a = base_a[kind] + 32'($urandom % sizes[kind]);
            else             a = $urandom;
            txn(a, $urandom, 4'($urandom), 1'($urandom), int'($urandom_range(1, 7)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_decoder.md
# mem_decoder

Parametrised memory-map decoder between the core's single memory port and NREG slave regions. It generalises the fixed ROM/print/CLINT/RAM address map into an N-region decoder with one outstanding transaction. It adds behaviour the fixed map lacks: a decode-miss error response and a per-transaction timeout. It sits directly after the core's memory interface and fans out to the ROM, print, CLINT, RAM and future peripherals.

## Interface
- NREG, 4, number of slave regions (1..8)
- REG_BASE, {32'h80000000, 32'h2000000, 32'h1000000, 32'h0}, packed 32*NREG base addresses, region i at bits [32*i+31:32*i]
- REG_TOP, {32'h90000000, 32'h200C000, 32'h1000004, 32'h80}, packed 32*NREG exclusive top addresses
- TIMEOUT, 255, cycles to wait for slave ready before error; 0 disables the timeout
- clock  in  1  system clock
- reset  in  1  synchronous active-low reset
- m_valid  in  1  request strobe from the core, one-cycle pulse
- m_instr  in  1  instruction fetch flag
- m_addr  in  32  byte address
- m_wdata  in  32  write data
- m_wstrb  in  4  byte write strobes; 0 means read
- m_rdata  out  32  read data, valid while m_ready=1
- m_ready  out  1  response pulse, one cycle
- m_error  out  1  error qualifier, valid only with m_ready
- s_valid  out  NREG  one-hot request pulse to the selected slave
- s_instr, s_addr[31:0], s_wdata[31:0], s_wstrb[3:0]  out  shared request fields, registered
- s_rdata  in  32*NREG  per-slave read data
- s_ready  in  NREG  per-slave response pulse

## Operation
- States: IDLE, BUSY, RESP.
- Reset (reset=0 at a clock edge) forces IDLE and clears state. All outputs read 0: m_ready, m_error, m_rdata, s_valid, s_instr, s_addr, s_wdata, s_wstrb and the timeout counter.
- IDLE with m_valid=1: decode the region. Region i hits when REG_BASE[i] <= m_addr < REG_TOP[i], using an unsigned 32-bit compare. On overlap, the lowest index wins.
- Hit:
  - Latch sel=i.
  - Next cycle, drive s_valid[i]=1 for exactly one cycle.
  - Drive s_addr = m_addr - REG_BASE[i], the 32-bit region offset, together with the latched instr, wdata and wstrb.
  - Go to BUSY.
- Miss: no s_valid. Go to RESP with error=1 and rdata=0.
- BUSY:
  - Count cycles from 1.
  - If s_ready[sel]=1, latch s_rdata[sel], set error=0 and go to RESP.
  - Otherwise, if TIMEOUT!=0 and count==TIMEOUT, set error=1, rdata=0 and go to RESP.
  - If s_ready and timeout fall in the same cycle, ready wins.
- RESP: drive m_ready=1 for one cycle with m_error and m_rdata, then return to IDLE.
- m_rdata holds its last value until the next response. A write response returns the slave's rdata unchanged.
- m_valid outside IDLE is ignored; the core guarantees one outstanding request.
- s_ready from non-selected slaves, or any s_ready outside BUSY, is ignored. A late ready after a timeout is dropped.
- Reset mid-transaction aborts the transaction: no m_ready is issued, and any pending slave response is discarded.

## Timing
- Hit latency: m_valid at cycle 0 gives s_valid at cycle 1. If the slave responds at cycle k >= 1, m_ready follows at k+1.
- A zero-wait slave responding in the same cycle as s_valid gives m_ready at cycle 2.
- Miss: m_valid at cycle 0 gives m_ready=1 and m_error=1 at cycle 2.
- Timeout: the BUSY count equals 1 at cycle 1, giving an m_error pulse at cycle TIMEOUT+1.
- Back-to-back throughput: a new m_valid is accepted on the cycle after m_ready (IDLE again).
- All outputs are registered; there is no combinational path from slave inputs to master outputs.

## Test plan
- Reset: hold reset=0 for 3 cycles with m_valid=1 and addr 0x80000000 -> all outputs 0 and no s_valid.
- RAM read hit: m_addr=0x80000010, wstrb=0; slave 3 responds 2 cycles after s_valid with rdata=0xDEADBEEF -> s_valid=4'b1000 at cycle 1, s_addr=0x10, m_ready at cycle 4 with m_rdata=0xDEADBEEF and m_error=0.
- Boundary decode:
  - 0x1000003 -> region 1.
  - 0x1000004 -> miss, m_error=1 at cycle 2.
  - 0x7F -> region 0.
  - 0x80 -> miss.
- Write: addr 0x2004000, wdata 0x12345678, wstrb 4'hF -> s_valid=4'b0100, s_addr=0x4000, wstrb forwarded, m_error=0.
- Timeout with TIMEOUT=4: slave never responds -> m_ready with m_error=1 at cycle 5. A late s_ready at cycle 7 produces no extra m_ready.
- Simultaneous and abort cases:
  - With TIMEOUT=4, slave ready at cycle 4 (timeout cycle) -> m_error=0 with data returned.
  - A reset pulse at cycle 2 of a RAM read -> no m_ready.
  - A later request is serviced normally.
